// File: rtl/tx_scrambler_ctrl.sv
// tx_scrambler_ctrl: PCIe transmit scrambler and 128b/130b block framer.
// Gen1/2 uses the 16-bit LFSR with COM/SKP rules; Gen3+ uses the 23-bit LFSR
// and tracks the symbol position inside each 16-symbol block.
// Optional build macro TX_SCR_DISABLE_EN adds input scrDisable: when high every
// symbol leaves unscrambled while both LFSRs keep stepping so the receiver stays
// aligned.
//
// state    | meaning
// IDLE     | no Gen3 block open; waiting for in_blockStart
// DATA_BLK | inside a data block (sync 01); every symbol scrambled
// OS_BLK   | inside an ordered-set block (sync 10); type latched from symbol 0
module tx_scrambler_ctrl #(
  parameter logic [22:0] SEED_G3  = 23'h1DBFBC,
  parameter logic [15:0] SEED_G12 = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  GEN,
  input  logic [5:0]  PIPEWIDTH,
  input  logic        turnOff,
`ifdef TX_SCR_DISABLE_EN
  input  logic        scrDisable,
`endif
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_dataK,
  input  logic [1:0]  in_syncHeader,
  input  logic        in_blockStart,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [3:0]  out_dataK,
  output logic [1:0]  out_syncHeader,
  output logic        out_blockStart,
  output logic        out_blkErr
);

  typedef enum logic [1:0] {IDLE, DATA_BLK, OS_BLK} state_t;

  state_t      state, state_n, st;
  logic [3:0]  sym_cnt, sym_cnt_n, cnt, pos, act, nbytes;
  logic [15:0] lfsr16, lfsr16_n;
  logic [22:0] lfsr23, lfsr23_n;
  logic [7:0]  os_type, os_type_n, sym, ks;
  logic        gen3, gen3_n, use_g3, com_any, err_n, scr_en;
  logic [31:0] data_n;
  logic [23:0] r16;
  logic [30:0] r23;

`ifdef TX_SCR_DISABLE_EN
  assign scr_en = ~scrDisable;
`else
  assign scr_en = 1'b1;
`endif

  // Eight serial steps of the Gen1/2 Galois LFSR: {next_state, keystream byte}.
  function automatic logic [23:0] g12_step8(input logic [15:0] s_in);
    logic [15:0] s;
    logic [7:0]  m;
    s = s_in;
    m = '0;
    for (int j = 0; j < 8; j++) begin
      m[j] = s[15];
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h0039 : 16'h0000);
    end
    return {s, m};
  endfunction

  // Eight serial steps of the Gen3 Galois LFSR: {next_state, keystream byte}.
  function automatic logic [30:0] g3_step8(input logic [22:0] s_in);
    logic [22:0] s;
    logic [7:0]  m;
    s = s_in;
    m = '0;
    for (int j = 0; j < 8; j++) begin
      m[j] = s[22];
      s = {s[21:0], 1'b0} ^ (s[22] ? 23'h210125 : 23'h000000);
    end
    return {s, m};
  endfunction

  // Per-word next state: symbol rules applied byte by byte, LFSR threaded serially.
  always_comb begin
    state_n   = state;
    sym_cnt_n = sym_cnt;
    lfsr16_n  = lfsr16;
    lfsr23_n  = lfsr23;
    os_type_n = os_type;
    data_n    = '0;
    err_n     = 1'b0;
    st        = state;
    cnt       = sym_cnt;
    pos       = '0;
    sym       = '0;
    ks        = '0;
    r16       = '0;
    r23       = '0;
    com_any   = 1'b0;
    case (PIPEWIDTH)
      6'd16:   begin act = 4'b0011; nbytes = 4'd2; end
      6'd32:   begin act = 4'b1111; nbytes = 4'd4; end
      default: begin act = 4'b0001; nbytes = 4'd1; end
    endcase
    for (int i = 0; i < 4; i++)
      if (act[i] && in_dataK[i] && in_data[8*i +: 8] == 8'hBC) com_any = 1'b1;
    // Generation switches only on a block boundary or a COM.
    if (in_blockStart)                 use_g3 = (GEN >= 3'd3);
    else if (GEN < 3'd3 && com_any)    use_g3 = 1'b0;
    else                               use_g3 = gen3;
    gen3_n = use_g3;

    if (!use_g3) begin
      for (int i = 0; i < 4; i++) begin
        if (act[i]) begin
          sym = in_data[8*i +: 8];
          r16 = g12_step8(lfsr16_n);
          data_n[8*i +: 8] = sym;
          if (turnOff) begin
            lfsr16_n = SEED_G12;
          end else if (in_dataK[i]) begin
            if (sym == 8'hBC)      lfsr16_n = SEED_G12;
            else if (sym != 8'h1C) lfsr16_n = r16[23:8];
          end else begin
            data_n[8*i +: 8] = sym ^ (scr_en ? r16[7:0] : 8'h00);
            lfsr16_n = r16[23:8];
          end
        end
      end
    end else begin
      if (in_blockStart) begin
        if (state != IDLE && sym_cnt != 4'd0) err_n = 1'b1;
        cnt = 4'd0;
        case (in_syncHeader)
          2'b01:   st = DATA_BLK;
          2'b10:   begin st = OS_BLK; os_type_n = in_data[7:0]; end
          default: begin st = IDLE; err_n = 1'b1; end
        endcase
      end else if (state != IDLE && sym_cnt == 4'd0) begin
        // previous block ended and this word does not open a new one
        err_n = 1'b1;
        st    = IDLE;
      end
      for (int i = 0; i < 4; i++) begin
        if (act[i]) begin
          sym = in_data[8*i +: 8];
          pos = cnt + 4'(i);
          r23 = g3_step8(lfsr23_n);
          ks  = scr_en ? r23[7:0] : 8'h00;
          data_n[8*i +: 8] = sym;
          case (st)
            DATA_BLK: begin
              data_n[8*i +: 8] = sym ^ ks;
              lfsr23_n = r23[30:8];
            end
            OS_BLK: begin
              if (os_type_n != 8'hAA) begin
                if ((os_type_n == 8'h1E || os_type_n == 8'h2D) && pos != 4'd0)
                  data_n[8*i +: 8] = sym ^ ks;
                lfsr23_n = r23[30:8];
              end
            end
            default: ;
          endcase
        end
      end
      if (st == IDLE) begin
        sym_cnt_n = 4'd0;
      end else begin
        sym_cnt_n = cnt + nbytes;
        if (st == OS_BLK && os_type_n == 8'h00 && sym_cnt_n == 4'd0)
          lfsr23_n = SEED_G3;
      end
      state_n = st;
    end
  end

  // Framing state, counters and LFSRs move only on valid words.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      sym_cnt <= 4'd0;
      lfsr16  <= SEED_G12;
      lfsr23  <= SEED_G3;
      os_type <= 8'h00;
      gen3    <= 1'b0;
    end else if (in_valid) begin
      state   <= state_n;
      sym_cnt <= sym_cnt_n;
      lfsr16  <= lfsr16_n;
      lfsr23  <= lfsr23_n;
      os_type <= os_type_n;
      gen3    <= gen3_n;
    end
  end

  // Output stage: one-cycle latency, payload held while in_valid is low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_dataK      <= '0;
      out_syncHeader <= '0;
      out_blockStart <= 1'b0;
      out_blkErr     <= 1'b0;
    end else begin
      out_valid  <= in_valid;
      out_blkErr <= in_valid & err_n;
      if (in_valid) begin
        out_data       <= data_n;
        out_dataK      <= in_dataK;
        out_syncHeader <= in_syncHeader;
        out_blockStart <= in_blockStart;
      end
    end
  end

endmodule

// File: tb/tb_tx_scrambler_ctrl.sv
// Bench for tx_scrambler_ctrl: keystream-index reference model plus directed
// vectors for the Gen1 COM/SKP and Gen3 block cases.
module tb_tx_scrambler_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  GEN;
  logic [5:0]  PIPEWIDTH;
  logic        turnOff;
`ifdef TX_SCR_DISABLE_EN
  logic        scrDisable;
`endif
  logic        in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_dataK;
  logic [1:0]  in_syncHeader;
  logic        in_blockStart;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_dataK;
  logic [1:0]  out_syncHeader;
  logic        out_blockStart;
  logic        out_blkErr;

  int checks = 0;
  int errors = 0;

  logic [7:0] ks16 [0:4095];
  logic [7:0] ks23 [0:4095];
  logic [7:0] g1_ref [8] = '{8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7, 8'h02, 8'h82};

  // reference model state: positions in the keystreams, block framing
  bit         m_g3;
  int         idx16, idx23;
  int         m_kind;   // 0 none, 1 data block, 2 ordered-set block
  int         m_pos;    // symbols consumed in the current block
  logic [7:0] m_type;
  logic [31:0] last_exp;

  always #5 clk = ~clk;

  tx_scrambler_ctrl dut (
    .clk(clk), .reset_n(reset_n), .GEN(GEN), .PIPEWIDTH(PIPEWIDTH), .turnOff(turnOff),
`ifdef TX_SCR_DISABLE_EN
    .scrDisable(scrDisable),
`endif
    .in_valid(in_valid), .in_data(in_data), .in_dataK(in_dataK),
    .in_syncHeader(in_syncHeader), .in_blockStart(in_blockStart),
    .out_valid(out_valid), .out_data(out_data), .out_dataK(out_dataK),
    .out_syncHeader(out_syncHeader), .out_blockStart(out_blockStart),
    .out_blkErr(out_blkErr)
  );

  task automatic gen_ks();
    logic [15:0] a;
    logic [22:0] b;
    logic        o;
    a = 16'hFFFF;
    b = 23'h1DBFBC;
    for (int n = 0; n < 4096; n++) begin
      for (int j = 0; j < 8; j++) begin
        o = a[15]; ks16[n][j] = o; a = {a[14:0], o}; if (o) a = a ^ 16'h0038;
        o = b[22]; ks23[n][j] = o; b = {b[21:0], o}; if (o) b = b ^ 23'h210124;
      end
    end
  endtask

  task automatic model_reset();
    m_g3 = 1'b0; idx16 = 0; idx23 = 0; m_kind = 0; m_pos = 0; m_type = 8'h00;
    last_exp = '0;
  endtask

  task automatic model_word(input logic [31:0] d, input logic [3:0] k, input logic [1:0] sh,
                            input bit bs, output logic [31:0] ed, output bit ee);
    int nb;
    bit com;
    logic [7:0] b;
    nb = (PIPEWIDTH == 6'd16) ? 2 : (PIPEWIDTH == 6'd32) ? 4 : 1;
    ed = '0; ee = 1'b0; com = 1'b0;
    for (int i = 0; i < nb; i++) if (k[i] && d[8*i +: 8] == 8'hBC) com = 1'b1;
    if (bs) m_g3 = (GEN >= 3);
    else if (GEN < 3 && com) m_g3 = 1'b0;
    if (!m_g3) begin
      for (int i = 0; i < nb; i++) begin
        b = d[8*i +: 8];
        ed[8*i +: 8] = b;
        if (turnOff) idx16 = 0;
        else if (k[i]) begin
          if (b == 8'hBC) idx16 = 0;
          else if (b != 8'h1C) idx16++;
        end else begin
          ed[8*i +: 8] = b ^ ks16[idx16];
          idx16++;
        end
      end
    end else begin
      if (bs) begin
        if (m_kind != 0 && m_pos < 16) ee = 1'b1;
        m_pos = 0;
        if (sh == 2'b01) m_kind = 1;
        else if (sh == 2'b10) begin m_kind = 2; m_type = d[7:0]; end
        else begin m_kind = 0; ee = 1'b1; end
      end else if (m_kind != 0 && m_pos == 16) begin
        ee = 1'b1; m_kind = 0;
      end
      for (int i = 0; i < nb; i++) begin
        b = d[8*i +: 8];
        ed[8*i +: 8] = b;
        if (m_kind == 1) begin
          ed[8*i +: 8] = b ^ ks23[idx23]; idx23++;
        end else if (m_kind == 2 && m_type != 8'hAA) begin
          if ((m_type == 8'h1E || m_type == 8'h2D) && m_pos != 0) ed[8*i +: 8] = b ^ ks23[idx23];
          idx23++;
        end
        if (m_kind != 0) m_pos++;
      end
      if (m_kind == 2 && m_type == 8'h00 && m_pos == 16) idx23 = 0;
    end
    last_exp = ed;
  endtask

  task automatic send(input bit v, input logic [31:0] d, input logic [3:0] k,
                      input logic [1:0] sh, input bit bs);
    in_valid = v; in_data = d; in_dataK = k; in_syncHeader = sh; in_blockStart = bs;
    @(posedge clk); #1;
  endtask

  task automatic xfer(input logic [31:0] d, input logic [3:0] k, input logic [1:0] sh,
                      input bit bs, output logic [31:0] ed, output bit ee);
    model_word(d, k, sh, bs, ed, ee);
    send(1'b1, d, k, sh, bs);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    send(1'b1, $urandom(), 4'hF, 2'b01, 1'b1);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    send(1'b1, 32'hDEADBEEF, 4'hF, 2'b10, 1'b1);
    checks += 6;
    if (out_valid !== 1'b0)      begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    if (out_data !== 32'h0)      begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
    if (out_dataK !== 4'h0)      begin errors++; $display("FAIL reset_dataK: got %h expected 0", out_dataK); end
    if (out_syncHeader !== 2'b0) begin errors++; $display("FAIL reset_sync: got %b expected 0", out_syncHeader); end
    if (out_blockStart !== 1'b0) begin errors++; $display("FAIL reset_bs: got %b expected 0", out_blockStart); end
    if (out_blkErr !== 1'b0)     begin errors++; $display("FAIL reset_err: got %b expected 0", out_blkErr); end
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_gen1_com();
    logic [31:0] ed, r;
    bit ee;
    GEN = 3'd1; PIPEWIDTH = 6'd8; turnOff = 1'b0;
    r = $urandom();
    xfer({r[31:8], 8'hBC}, {r[3:1], 1'b1}, 2'b00, 1'b0, ed, ee);
    checks++;
    if (out_data !== 32'h000000BC) begin errors++; $display("FAIL g1_com: got %h expected 000000bc", out_data); end
    for (int n = 0; n < 8; n++) begin
      r = $urandom();
      xfer({r[31:8], 8'h00}, {r[3:1], 1'b0}, 2'b00, 1'b0, ed, ee);
      checks++;
      if (out_data !== {24'h0, g1_ref[n]} || out_valid !== 1'b1) begin
        errors++; $display("FAIL g1_d00[%0d]: got %h v=%b expected %h", n, out_data, out_valid, g1_ref[n]);
      end
    end
  endtask

  task automatic test_gen1_skp();
    logic [31:0] ed;
    bit ee;
    GEN = 3'd1; PIPEWIDTH = 6'd32; turnOff = 1'b0;
    xfer(32'hBC1C1C00, 4'b1110, 2'b00, 1'b0, ed, ee);
    checks += 2;
    if (out_data[23:8] !== 16'h1C1C) begin errors++; $display("FAIL g1_skp_pass: got %h expected 1c1c", out_data[23:8]); end
    if (out_data !== ed) begin errors++; $display("FAIL g1_skp_word: got %h expected %h", out_data, ed); end
    xfer(32'h0, 4'h0, 2'b00, 1'b0, ed, ee);
    checks++;
    if (out_data !== 32'h14C017FF) begin errors++; $display("FAIL g1_post_com: got %h expected 14c017ff", out_data); end
    xfer(32'h00001C00, 4'b0010, 2'b00, 1'b0, ed, ee);
    checks++;
    if (out_data !== 32'h02E71CB2) begin errors++; $display("FAIL g1_skp_hold: got %h expected 02e71cb2", out_data); end
  endtask

  task automatic test_gen1_random();
    logic [31:0] ed, d, r;
    logic [3:0]  k;
    bit ee;
    int c;
    GEN = 3'($urandom_range(0, 2)); PIPEWIDTH = 6'd8; turnOff = 1'b0;
    xfer(32'h000000BC, 4'h1, 2'b00, 1'b0, ed, ee);
    for (int n = 0; n < 150; n++) begin
      if ($urandom() % 5 == 0) begin
        send(1'b0, $urandom(), 4'($urandom()), 2'($urandom()), 1'b0);
        checks++;
        if (out_valid !== 1'b0 || out_data !== last_exp || out_blkErr !== 1'b0) begin
          errors++; $display("FAIL g1_idle: v=%b data=%h err=%b expected v=0 data=%h", out_valid, out_data, out_blkErr, last_exp);
        end
      end else begin
        c = $urandom_range(0, 2);
        PIPEWIDTH = (c == 0) ? 6'd8 : (c == 1) ? 6'd16 : 6'd32;
        turnOff = ($urandom() % 8 == 0);
        d = $urandom(); k = '0;
        for (int i = 0; i < 4; i++) begin
          c = $urandom_range(0, 9);
          if (c == 7) begin d[8*i +: 8] = 8'hBC; k[i] = 1'b1; end
          else if (c == 8) begin d[8*i +: 8] = 8'h1C; k[i] = 1'b1; end
          else if (c == 9) begin r = $urandom(); d[8*i +: 8] = r[7:0]; k[i] = 1'b1; end
        end
        xfer(d, k, 2'b00, 1'b0, ed, ee);
        checks++;
        if (out_data !== ed || out_valid !== 1'b1 || out_blkErr !== 1'b0) begin
          errors++; $display("FAIL g1_rand[%0d]: data=%h v=%b err=%b expected %h", n, out_data, out_valid, out_blkErr, ed);
        end
      end
    end
    turnOff = 1'b0;
  endtask

  task automatic test_gen3_skp_data();
    logic [31:0] ed, d, dx;
    bit ee;
    do_reset();
    GEN = 3'd3; PIPEWIDTH = 6'd32; turnOff = 1'b0;
    for (int w = 0; w < 4; w++) begin
      xfer(32'hAAAAAAAA, 4'h0, 2'b10, (w == 0), ed, ee);
      checks++;
      if (out_data !== 32'hAAAAAAAA || out_blkErr !== 1'b0) begin
        errors++; $display("FAIL g3_skp[%0d]: data=%h err=%b expected aaaaaaaa", w, out_data, out_blkErr);
      end
    end
    for (int w = 0; w < 4; w++) begin
      d = $urandom();
      for (int j = 0; j < 4; j++) dx[8*j +: 8] = d[8*j +: 8] ^ ks23[4*w + j];
      xfer(d, 4'h0, 2'b01, (w == 0), ed, ee);
      checks++;
      if (out_data !== dx || out_blkErr !== 1'b0) begin
        errors++; $display("FAIL g3_data_after_skp[%0d]: data=%h err=%b expected %h", w, out_data, out_blkErr, dx);
      end
    end
  endtask

  task automatic test_gen3_eieos_ts1();
    logic [31:0] ed, d, dx;
    bit ee;
    GEN = 3'd3; PIPEWIDTH = 6'd32;
    for (int w = 0; w < 4; w++) begin
      xfer(32'hFF00FF00, 4'h0, 2'b10, (w == 0), ed, ee);
      checks++;
      if (out_data !== 32'hFF00FF00) begin errors++; $display("FAIL g3_eieos[%0d]: got %h expected ff00ff00", w, out_data); end
    end
    for (int w = 0; w < 4; w++) begin
      d = $urandom();
      if (w == 0) d[7:0] = 8'h1E;
      for (int j = 0; j < 4; j++) dx[8*j +: 8] = d[8*j +: 8] ^ ks23[4*w + j];
      if (w == 0) dx[7:0] = 8'h1E;
      xfer(d, 4'h0, 2'b10, (w == 0), ed, ee);
      checks++;
      if (out_data !== dx) begin errors++; $display("FAIL g3_ts1[%0d]: got %h expected %h", w, out_data, dx); end
    end
  endtask

  task automatic test_blkstart_err();
    logic [31:0] ed;
    bit ee;
    do_reset();
    GEN = 3'd3; PIPEWIDTH = 6'd16;
    for (int w = 0; w < 3; w++) begin
      xfer($urandom(), 4'h0, 2'b01, (w == 0), ed, ee);
      checks++;
      if (out_data !== ed || out_blkErr !== 1'b0) begin
        errors++; $display("FAIL early_pre[%0d]: data=%h err=%b expected %h err=0", w, out_data, out_blkErr, ed);
      end
    end
    xfer($urandom(), 4'h0, 2'b01, 1'b1, ed, ee);
    checks += 2;
    if (out_blkErr !== 1'b1) begin errors++; $display("FAIL early_start_err: got %b expected 1", out_blkErr); end
    if (out_data !== ed || out_blockStart !== 1'b1) begin
      errors++; $display("FAIL early_start_data: data=%h bs=%b expected %h bs=1", out_data, out_blockStart, ed);
    end
    for (int w = 1; w < 8; w++) begin
      xfer($urandom(), 4'h0, 2'b01, 1'b0, ed, ee);
      checks++;
      if (out_data !== ed || out_blkErr !== 1'b0) begin
        errors++; $display("FAIL early_refr[%0d]: data=%h err=%b expected %h err=0", w, out_data, out_blkErr, ed);
      end
    end
    xfer(32'h12345678, 4'h0, 2'b01, 1'b0, ed, ee);
    checks++;
    if (out_blkErr !== 1'b1 || out_data !== 32'h00005678) begin
      errors++; $display("FAIL missing_start: err=%b data=%h expected err=1 data=00005678", out_blkErr, out_data);
    end
    xfer(32'h0000ABCD, 4'h0, 2'b11, 1'b1, ed, ee);
    checks++;
    if (out_blkErr !== 1'b1 || out_data !== 32'h0000ABCD) begin
      errors++; $display("FAIL bad_sync: err=%b data=%h expected err=1 data=0000abcd", out_blkErr, out_data);
    end
  endtask

  task automatic test_gen3_random();
    logic [31:0] ed, d;
    logic [1:0]  sh;
    logic [7:0]  ty;
    bit ee;
    int c, nw;
    do_reset();
    c = $urandom_range(0, 2);
    PIPEWIDTH = (c == 0) ? 6'd8 : (c == 1) ? 6'd16 : 6'd32;
    for (int blk = 0; blk < 25; blk++) begin
      GEN = 3'($urandom_range(3, 7));
      sh = ($urandom() % 10 == 0) ? (($urandom() % 2) ? 2'b00 : 2'b11) : (($urandom() % 2) ? 2'b01 : 2'b10);
      c = $urandom_range(0, 4);
      ty = (c == 0) ? 8'h00 : (c == 1) ? 8'hAA : (c == 2) ? 8'h1E : (c == 3) ? 8'h2D : 8'($urandom());
      nw = 16 / (PIPEWIDTH / 8);
      if ($urandom() % 8 == 0) nw = $urandom_range(1, nw - 1);
      if ($urandom() % 8 == 0) nw = nw + $urandom_range(1, 2);
      for (int w = 0; w < nw; w++) begin
        if ($urandom() % 6 == 0) begin
          send(1'b0, $urandom(), 4'h0, 2'($urandom()), 1'($urandom()));
          checks++;
          if (out_valid !== 1'b0 || out_data !== last_exp || out_blkErr !== 1'b0) begin
            errors++; $display("FAIL g3_idle: v=%b data=%h err=%b expected v=0 data=%h", out_valid, out_data, out_blkErr, last_exp);
          end
        end
        d = $urandom();
        if (w == 0) d[7:0] = ty;
        xfer(d, 4'($urandom()), sh, (w == 0), ed, ee);
        checks++;
        if (out_data !== ed || out_blkErr !== ee || out_valid !== 1'b1) begin
          errors++; $display("FAIL g3_rand[%0d.%0d]: data=%h err=%b expected %h err=%b", blk, w, out_data, out_blkErr, ed, ee);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ed, d, dx;
    bit ee;
    GEN = 3'd3; PIPEWIDTH = 6'd32;
    xfer($urandom(), 4'h0, 2'b01, 1'b1, ed, ee);
    xfer($urandom(), 4'h0, 2'b01, 1'b0, ed, ee);
    reset_n = 1'b0;
    for (int n = 0; n < 2; n++) begin
      send(1'b1, $urandom(), 4'hF, 2'b01, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || out_blkErr !== 1'b0 || out_dataK !== 4'h0) begin
        errors++; $display("FAIL mid_reset[%0d]: v=%b data=%h err=%b k=%h expected all 0", n, out_valid, out_data, out_blkErr, out_dataK);
      end
    end
    reset_n = 1'b1;
    model_reset();
    GEN = 3'd1; PIPEWIDTH = 6'd8;
    xfer(32'h000000BC, 4'h1, 2'b00, 1'b0, ed, ee);
    for (int n = 0; n < 4; n++) begin
      xfer(32'h0, 4'h0, 2'b00, 1'b0, ed, ee);
      checks++;
      if (out_data !== {24'h0, g1_ref[n]}) begin
        errors++; $display("FAIL restart_g1[%0d]: got %h expected %h", n, out_data, g1_ref[n]);
      end
    end
    do_reset();
    GEN = 3'd4; PIPEWIDTH = 6'd32;
    for (int w = 0; w < 4; w++) begin
      d = $urandom();
      for (int j = 0; j < 4; j++) dx[8*j +: 8] = d[8*j +: 8] ^ ks23[4*w + j];
      xfer(d, 4'h0, 2'b01, (w == 0), ed, ee);
      checks++;
      if (out_data !== dx || out_blkErr !== 1'b0) begin
        errors++; $display("FAIL restart_g3[%0d]: data=%h err=%b expected %h", w, out_data, out_blkErr, dx);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; GEN = 3'd1; PIPEWIDTH = 6'd8; turnOff = 1'b0;
`ifdef TX_SCR_DISABLE_EN
    scrDisable = 1'b0;
`endif
    in_valid = 1'b0; in_data = '0; in_dataK = '0; in_syncHeader = '0; in_blockStart = 1'b0;
    gen_ks();
    model_reset();
    #2;
    test_reset();
    test_gen1_com();
    test_gen1_skp();
    test_gen1_random();
    test_gen3_skp_data();
    test_gen3_eieos_ts1();
    test_blkstart_err();
    test_gen3_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
